// File: rtl/uart_event_rx_if.sv
// Byte stream in from the UART receiver, decoded event frames out.
interface uart_event_rx_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       block;
  logic [7:0] evento;
  logic [3:0] linha;
  logic [3:0] coluna;
  logic [3:0] valor;
  logic [1:0] dificuldade;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  // Byte source / event consumer side
  modport master (
    output rx_data, rx_done, block,
    input  evento, linha, coluna, valor, dificuldade, data_valid, frame_error, busy
  );

  // Decoder side
  modport slave (
    input  rx_data, rx_done, block,
    output evento, linha, coluna, valor, dificuldade, data_valid, frame_error, busy
  );
endinterface

// File: rtl/uart_event_rx.sv
// Event frame decoder: code byte + 0..2 payload bytes -> validated fields.
module uart_event_rx #(
  parameter logic [7:0] EVT_NEW        = 8'hA0,
  parameter logic [7:0] EVT_MOVE       = 8'hA1,
  parameter logic [7:0] EVT_END        = 8'hAB,
  parameter int         TIMEOUT_CYCLES = 50_000_000,
  parameter int         CNT_W          = 26
) (
  input  logic           clk,
  input  logic           reset,
  uart_event_rx_if.slave bus
);

  // The timeout counter must reach its expiry value without wrapping.
  if (64'(TIMEOUT_CYCLES) >= (64'd1 << CNT_W) || TIMEOUT_CYCLES < 1) begin : g_cnt_chk
    $error("uart_event_rx: TIMEOUT_CYCLES does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PAYLOAD1, PAYLOAD2} state_t;

  state_t           state_q;
  logic [7:0]       code_q;
  logic [7:0]       byte1_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       evento_q;
  logic [3:0]       linha_q, coluna_q, valor_q;
  logic [1:0]       dif_q;
  logic             data_valid_q, frame_error_q;

  logic move_ok;
  logic new_ok;

  // Field checks for the final payload byte of each frame type.
  assign new_ok  = (bus.rx_data <= 8'd2);
  assign move_ok = (byte1_q[7:4] <= 4'd8) && (byte1_q[3:0] <= 4'd8) &&
                   (bus.rx_data[7:4] == 4'd0) && (bus.rx_data[3:0] != 4'd0) &&
                   (bus.rx_data[3:0] <= 4'd9);

  // Frame assembly FSM with registered field outputs and pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      code_q        <= '0;
      byte1_q       <= '0;
      cnt_q         <= '0;
      evento_q      <= '0;
      linha_q       <= '0;
      coluna_q      <= '0;
      valor_q       <= '0;
      dif_q         <= '0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (bus.rx_done) begin
            if (bus.rx_data == EVT_END) begin
              if (!bus.block) begin
                evento_q     <= bus.rx_data;
                data_valid_q <= 1'b1;
              end
            end else if (bus.rx_data == EVT_NEW || bus.rx_data == EVT_MOVE) begin
              code_q  <= bus.rx_data;
              state_q <= PAYLOAD1;
            end else begin
              // Unknown code is not a frame, so block does not suppress it.
              frame_error_q <= 1'b1;
            end
          end
        end
        PAYLOAD1: begin
          if (bus.rx_done) begin
            cnt_q <= '0;
            if (code_q == EVT_NEW) begin
              state_q <= IDLE;
              if (!bus.block) begin
                if (new_ok) begin
                  evento_q     <= code_q;
                  dif_q        <= bus.rx_data[1:0];
                  data_valid_q <= 1'b1;
                end else begin
                  frame_error_q <= 1'b1;
                end
              end
            end else begin
              byte1_q <= bus.rx_data;
              state_q <= PAYLOAD2;
            end
          end else if (cnt_q == CNT_LAST) begin
            frame_error_q <= 1'b1;
            cnt_q         <= '0;
            state_q       <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PAYLOAD2: begin
          if (bus.rx_done) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (!bus.block) begin
              if (move_ok) begin
                evento_q     <= code_q;
                linha_q      <= byte1_q[7:4];
                coluna_q     <= byte1_q[3:0];
                valor_q      <= bus.rx_data[3:0];
                data_valid_q <= 1'b1;
              end else begin
                frame_error_q <= 1'b1;
              end
            end
          end else if (cnt_q == CNT_LAST) begin
            frame_error_q <= 1'b1;
            cnt_q         <= '0;
            state_q       <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.evento      = evento_q;
  assign bus.linha       = linha_q;
  assign bus.coluna      = coluna_q;
  assign bus.valor       = valor_q;
  assign bus.dificuldade = dif_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.frame_error = frame_error_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_event_rx.sv
// Scoreboard bench: frame-level reference model predicts pulses, monitor checks them.
module tb_uart_event_rx;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic reset = 1'b1;
  uart_event_rx_if bus ();

  uart_event_rx #(.TIMEOUT_CYCLES(TO), .CNT_W(26)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    int         cyc;
    logic [7:0] ev;
    logic [3:0] l, c, v;
    logic [1:0] d;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;

  // reference model state
  logic [7:0] frame[$];
  int         silence = 0;
  bit         mdl_busy = 1'b0;
  logic [7:0] m_ev = '0;
  logic [3:0] m_l = '0, m_c = '0, m_v = '0;
  logic [1:0] m_d = '0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push(bit is_err);
    exp_t e;
    e.is_err = is_err; e.cyc = cyc + 1;
    e.ev = m_ev; e.l = m_l; e.c = m_c; e.v = m_v; e.d = m_d;
    q.push_back(e);
  endfunction

  // Frame-level semantics: length from code byte, validate when complete.
  function automatic void model_step(bit done, logic [7:0] d, bit blk);
    int need;
    if (done) begin
      silence = 0;
      frame.push_back(d);
      need = (frame[0] == 8'hAB) ? 1 : (frame[0] == 8'hA0) ? 2 : (frame[0] == 8'hA1) ? 3 : 0;
      if (need == 0) begin
        push(1'b1);
        frame.delete();
      end else if (frame.size() == need) begin
        if (!blk) begin
          if (need == 1) begin
            m_ev = 8'hAB; push(1'b0);
          end else if (need == 2) begin
            if (int'(frame[1]) <= 2) begin
              m_ev = 8'hA0; m_d = 2'(int'(frame[1])); push(1'b0);
            end else push(1'b1);
          end else begin
            int r, c, v;
            r = int'(frame[1]) / 16; c = int'(frame[1]) % 16; v = int'(frame[2]);
            if (r <= 8 && c <= 8 && v >= 1 && v <= 9) begin
              m_ev = 8'hA1; m_l = 4'(r); m_c = 4'(c); m_v = 4'(v); push(1'b0);
            end else push(1'b1);
          end
        end
        frame.delete();
      end
    end else if (frame.size() > 0) begin
      silence++;
      if (silence == TO) begin
        push(1'b1);
        frame.delete();
        silence = 0;
      end
    end
    mdl_busy = (frame.size() > 0);
  endfunction

  task automatic drive(input bit done, input logic [7:0] d, input bit blk);
    @(negedge clk);
    reset       = 1'b0;
    bus.rx_done = done;
    bus.rx_data = done ? d : 8'($urandom);
    bus.block   = blk;
    model_step(done, d, blk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'($urandom));
  endtask

  task automatic send(input int n, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input bit blk);
    logic [7:0] b[3];
    b[0] = b0; b[1] = b1; b[2] = b2;
    for (int i = 0; i < n; i++) drive(1'b1, b[i], (i == n - 1) ? blk : 1'($urandom));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.rx_done = 1'b0;
    frame.delete(); silence = 0; mdl_busy = 1'b0;
    m_ev = '0; m_l = '0; m_c = '0; m_v = '0; m_d = '0;
    q.delete();
    @(posedge clk); #1;
    chk("rst_evento", int'(bus.evento), 0);
    chk("rst_linha", int'(bus.linha), 0);
    chk("rst_coluna", int'(bus.coluna), 0);
    chk("rst_valor", int'(bus.valor), 0);
    chk("rst_dif", int'(bus.dificuldade), 0);
    chk("rst_dv", int'(bus.data_valid), 0);
    chk("rst_fe", int'(bus.frame_error), 0);
    chk("rst_busy", int'(bus.busy), 0);
  endtask

  // Monitor: busy every cycle, pulses against scoreboard queue.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      chk("busy", int'(bus.busy), int'(mdl_busy));
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missing_pulse_at", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (bus.data_valid || bus.frame_error) begin
        chk("dv_fe_exclusive", int'(bus.data_valid & bus.frame_error), 0);
        if (q.size() == 0 || q[0].cyc != cyc) begin
          chk("unexpected_pulse_dv_fe", int'({bus.data_valid, bus.frame_error}), 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("pulse_is_err", int'(bus.frame_error), int'(e.is_err));
          chk("pulse_is_dv", int'(bus.data_valid), int'(!e.is_err));
          chk("evento", int'(bus.evento), int'(e.ev));
          chk("linha", int'(bus.linha), int'(e.l));
          chk("coluna", int'(bus.coluna), int'(e.c));
          chk("valor", int'(bus.valor), int'(e.v));
          chk("dificuldade", int'(bus.dificuldade), int'(e.d));
        end
      end
    end
  end

  initial begin
    bus.rx_done = 1'b0; bus.rx_data = '0; bus.block = 1'b0;
    do_reset();

    // directed cases
    send(1, 8'hAB, 0, 0, 1'b0);            idle(2);
    send(3, 8'hA1, 8'h35, 8'h07, 1'b0);
    send(1, 8'hAB, 0, 0, 1'b0);            idle(2);
    send(3, 8'hA1, 8'h95, 8'h07, 1'b0);    idle(2);
    send(2, 8'hA0, 8'h03, 0, 1'b0);        idle(2);
    send(1, 8'h55, 0, 0, 1'b0);            idle(2);
    send(2, 8'hA0, 8'h02, 0, 1'b1);        idle(2);
    send(2, 8'hA0, 8'h02, 0, 1'b0);        idle(2);
    send(1, 8'hA1, 0, 0, 1'b0);            idle(TO + 5);
    send(1, 8'hA1, 0, 0, 1'b0);            idle(TO - 1);
    send(2, 8'h35, 8'h07, 0, 1'b0);        idle(3);
    send(2, 8'hA1, 8'h35, 0, 1'b0);
    do_reset();
    send(1, 8'h07, 0, 0, 1'b0);            idle(3);

    // randomized frames
    for (int n = 0; n < 300; n++) begin
      int kind;
      bit blk;
      kind = int'($urandom_range(0, 4));
      blk = ($urandom_range(0, 3) == 0);
      case (kind)
        0: send(1, 8'hAB, 0, 0, blk);
        1: send(2, 8'hA0, 8'($urandom_range(0, 4)), 0, blk);
        2: send(3, 8'hA1, {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))},
                8'($urandom_range(0, 10)) | (($urandom_range(0, 7) == 0) ? 8'h10 : 8'h00), blk);
        3: send(1, 8'($urandom), 0, 0, blk);
        default: send(3, 8'hA1, 8'($urandom), 8'($urandom), blk);
      endcase
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 60) == 0) idle(TO + 2);
    end
    idle(5);
    chk("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_event_rx.md
Name: uart_event_rx

Overview:
- Host-to-board command decoder.
- Consumes bytes from the UART receiver and assembles them into event frames: one event code byte followed by 0–2 payload bytes.
- Validates each frame and delivers it as a one-cycle `data_valid` pulse with decoded fields.
- Feeds the game FSMs, including end_game_tx, which reacts to `evento == 8'hAB`.

Parameters:
- EVT_NEW, 8'hA0, new-game event code; 1 payload byte (difficulty).
- EVT_MOVE, 8'hA1, move event code; 2 payload bytes ({linha,coluna}, valor).
- EVT_END, 8'hAB, end-game request code; 0 payload bytes.
- TIMEOUT_CYCLES, 50_000_000, maximum idle cycles between bytes of one frame.
- CNT_W, 26, width of the inter-byte timeout counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  byte from UART receiver; valid only when rx_done=1
- rx_done  in  1  one-cycle pulse, new byte on rx_data
- block  in  1  high = completed frames are discarded (game busy)
- evento  out  8  event code of last delivered frame
- linha  out  4  row of last delivered move (0–8)
- coluna  out  4  column of last delivered move (0–8)
- valor  out  4  digit of last delivered move (1–9)
- dificuldade  out  2  difficulty of last delivered new-game (0–2)
- data_valid  out  1  one-cycle pulse, frame delivered
- frame_error  out  1  one-cycle pulse, frame rejected
- busy  out  1  high while a frame is partially received

Behaviour:
- Reset (synchronous, active-high, applies from any state, including mid-frame):
  - state=IDLE; all outputs 0; timeout counter 0; partially received bytes discarded.
- States: IDLE, PAYLOAD1, PAYLOAD2. `busy` = (state != IDLE).
- IDLE, on rx_done:
  - code==EVT_END: frame complete; deliver.
  - code==EVT_NEW or EVT_MOVE: latch code, go PAYLOAD1.
  - Any other code: frame_error pulse, stay IDLE.
- PAYLOAD1, on rx_done:
  - For EVT_NEW: check byte ≤ 8'd2, then deliver (dificuldade = byte[1:0]); else error.
  - For EVT_MOVE: latch the byte, go PAYLOAD2.
- PAYLOAD2, on rx_done:
  - Valid when high nibble of byte1 ≤ 8, low nibble of byte1 ≤ 8, and byte2 in 1..9 with byte2[7:4]==0.
  - If valid: deliver with linha=byte1[7:4], coluna=byte1[3:0], valor=byte2[3:0]; else error.
- Deliver:
  - In the cycle after the final rx_done, data_valid=1 for exactly one cycle.
  - evento and that event's field outputs update in that same edge; fields not carried by the event hold their previous value.
  - Return to IDLE.
- block:
  - Sampled on the final byte's rx_done cycle.
  - If high, the frame is silently dropped: no data_valid, no frame_error, outputs unchanged, return to IDLE.
  - block does not affect reception of earlier bytes.
- Error:
  - frame_error=1 for one cycle, in the cycle after the offending rx_done.
  - Outputs unchanged; return to IDLE.
  - An invalid frame's payload byte is never reinterpreted as a new code.
- Timeout:
  - Counter clears on every rx_done and while in IDLE; increments each cycle in PAYLOAD1/PAYLOAD2.
  - When the counter reaches TIMEOUT_CYCLES-1 with no rx_done that cycle: frame_error pulse next cycle, go IDLE, counter clears.
  - rx_done in the same cycle as expiry: the byte wins and is processed normally.
- data_valid and frame_error are never high together.
- Maximum throughput is one byte per cycle; back-to-back frames need no gap cycle.
- Counter saturates only via timeout; no wrap occurs because TIMEOUT_CYCLES < 2^CNT_W (elaboration check).

Test Plan:
- End-game delivery: bytes AB with block=0 → data_valid one cycle after rx_done, evento=AB, busy never high.
- Valid move: bytes A1, 35, 07 → data_valid, evento=A1, linha=3, coluna=5, valor=7; then AB back-to-back → second data_valid, linha/coluna/valor still 3/5/7.
- Rejected frames:
  - Bytes A1, 95, 07 (row 9) → frame_error, no data_valid, outputs unchanged.
  - Bytes A0, 03 → frame_error.
  - Byte 55 → frame_error in IDLE.
- block handling: bytes A0, 02 with block=1 on final byte → neither pulse, dificuldade unchanged; repeat with block=0 → data_valid, dificuldade=2.
- Timeout (TIMEOUT_CYCLES=100):
  - A1 then silence → frame_error exactly 100 cycles after entering PAYLOAD1, busy drops.
  - A1, then 35 arriving on the expiry cycle → accepted, no error.
- Reset mid-frame: A1, 35, assert reset one cycle, then 07 → 07 treated as unknown code → frame_error; all outputs 0 after reset.
